// File: rtl/abr_alert_ping_sched_pkg.sv
// Shared types and helpers for the alert ping scheduler.
// Round-robin search is kept here so other blocks can reuse it.
package abr_alert_ping_sched_pkg;

   typedef enum logic [1:0] {
      Idle,
      Wait,
      Ping
   } state_e;

   localparam int MinTimeout = 1;
   localparam int MaxAlerts  = 32;
   localparam int MaxIdxW    = $clog2(MaxAlerts);

   // First enabled index strictly after cur, wrapping; cur itself if alone
   function automatic int next_rr_idx(
      input logic [MaxAlerts-1:0] en_vec,
      input int                   n,
      input int                   cur
   );
      int res;
      res = cur;
      for (int i = n; i > 0; i--) begin
         if (en_vec[MaxIdxW'((cur + i) % n)]) begin
            res = (cur + i) % n;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/abr_rr_next_idx.sv
// Wrap-around priority search for the next enabled channel.
// Purely combinational; the scheduler registers the result.
module abr_rr_next_idx
   import abr_alert_ping_sched_pkg::*;
#(
   parameter int N    = 4,
   parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    en_vec,
   input  logic [IdxW-1:0] cur,
   output logic [IdxW-1:0] nxt,
   output logic            vld
);

   logic [MaxAlerts-1:0] en_ext;

   // Widen the enable vector and pick the next index after cur
   always_comb begin
      en_ext         = '0;
      en_ext[N-1:0]  = en_vec;
      nxt            = IdxW'(next_rr_idx(en_ext, N, int'(cur)));
      vld            = |en_vec;
   end

endmodule

// File: rtl/abr_alert_ping_sched.sv
// Periodic round-robin ping scheduler for alert receivers.
// Holds each ping until OK, abort or timeout; flags failures.
module abr_alert_ping_sched
   import abr_alert_ping_sched_pkg::*;
#(
   parameter int NumAlerts = 4,
   parameter int CntW      = 16,
   parameter int IdxW      = (NumAlerts > 1) ? $clog2(NumAlerts) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [NumAlerts-1:0] alert_en_i,
   input  logic [CntW-1:0]      wait_cyc_i,
   input  logic [CntW-1:0]      timeout_cyc_i,
   input  logic [NumAlerts-1:0] ping_ok_i,
   output logic [NumAlerts-1:0] ping_req_o,
   output logic                 ping_fail_o,
   output logic [IdxW-1:0]      fail_idx_o,
   output logic [NumAlerts-1:0] fail_sticky_o,
   input  logic [NumAlerts-1:0] fail_clr_i,
   output logic                 spurious_ok_o,
   output logic                 busy_o
);

   state_e            state;
   logic [CntW-1:0]   wait_cnt;
   logic [CntW-1:0]   tmo_cnt;
   logic [IdxW-1:0]   cur_idx;
   logic [IdxW-1:0]   rr_nxt;
   logic              rr_vld;
   logic [CntW-1:0]   tmo_load;

   abr_rr_next_idx #(
      .N    (NumAlerts),
      .IdxW (IdxW)
   ) u_rr (
      .en_vec (alert_en_i),
      .cur    (cur_idx),
      .nxt    (rr_nxt),
      .vld    (rr_vld)
   );

   // A zero timeout would never fire, so clamp to the minimum
   always_comb begin
      tmo_load = timeout_cyc_i;
      if (timeout_cyc_i < CntW'(MinTimeout)) begin
         tmo_load = CntW'(MinTimeout);
      end
   end

   assign busy_o = (state == Ping);

   // Scheduler FSM with registered request, fail and spurious outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= Idle;
         wait_cnt      <= '0;
         tmo_cnt       <= '0;
         cur_idx       <= IdxW'(NumAlerts - 1);
         ping_req_o    <= '0;
         ping_fail_o   <= 1'b0;
         fail_idx_o    <= '0;
         fail_sticky_o <= '0;
         spurious_ok_o <= 1'b0;
      end else begin
         ping_fail_o   <= 1'b0;
         spurious_ok_o <= |(ping_ok_i & ~ping_req_o);
         fail_sticky_o <= fail_sticky_o & ~fail_clr_i;
         if (!en_i) begin
            state      <= Idle;
            ping_req_o <= '0;
         end else begin
            unique case (state)
               Idle: begin
                  state    <= Wait;
                  wait_cnt <= wait_cyc_i;
               end
               Wait: begin
                  if (wait_cnt != '0) begin
                     wait_cnt <= wait_cnt - 1'b1;
                  end else if (rr_vld) begin
                     cur_idx    <= rr_nxt;
                     tmo_cnt    <= tmo_load;
                     state      <= Ping;
                     ping_req_o <= NumAlerts'(1) << rr_nxt;
                  end
               end
               Ping: begin
                  if (ping_ok_i[cur_idx] || !alert_en_i[cur_idx]) begin
                     state      <= Wait;
                     wait_cnt   <= wait_cyc_i;
                     ping_req_o <= '0;
                  end else if (tmo_cnt == CntW'(1)) begin
                     state                  <= Wait;
                     wait_cnt               <= wait_cyc_i;
                     ping_req_o             <= '0;
                     ping_fail_o            <= 1'b1;
                     fail_idx_o             <= cur_idx;
                     fail_sticky_o[cur_idx] <= 1'b1;
                  end else begin
                     tmo_cnt <= tmo_cnt - 1'b1;
                  end
               end
               default: begin
                  state      <= Idle;
                  ping_req_o <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_abr_alert_ping_sched.sv
// Scoreboard bench for abr_alert_ping_sched.
// Reference model predicts each cycle; a monitor compares.
module tb_abr_alert_ping_sched;

   localparam int N  = 4;
   localparam int CW = 16;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          en_i = 1'b0;
   logic [N-1:0]  alert_en_i = '0;
   logic [CW-1:0] wait_cyc_i = '0;
   logic [CW-1:0] timeout_cyc_i = '0;
   logic [N-1:0]  ping_ok_i = '0;
   logic [N-1:0]  fail_clr_i = '0;
   logic [N-1:0]  ping_req_o;
   logic          ping_fail_o;
   logic [1:0]    fail_idx_o;
   logic [N-1:0]  fail_sticky_o;
   logic          spurious_ok_o;
   logic          busy_o;

   abr_alert_ping_sched #(
      .NumAlerts (N),
      .CntW      (CW)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .en_i          (en_i),
      .alert_en_i    (alert_en_i),
      .wait_cyc_i    (wait_cyc_i),
      .timeout_cyc_i (timeout_cyc_i),
      .ping_ok_i     (ping_ok_i),
      .ping_req_o    (ping_req_o),
      .ping_fail_o   (ping_fail_o),
      .fail_idx_o    (fail_idx_o),
      .fail_sticky_o (fail_sticky_o),
      .fail_clr_i    (fail_clr_i),
      .spurious_ok_o (spurious_ok_o),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [N-1:0] req;
      logic         fail;
      logic [1:0]   idx;
      logic [N-1:0] sticky;
      logic         spur;
      logic         busy;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // stimulus shadow, applied at the next falling edge
   bit           s_en;
   logic [N-1:0] s_aen, s_clr, s_spur;
   int           s_wait, s_tmo;
   int           dly[N];

   // reference model: phase 0 idle, 1 gap, 2 pinging
   int           m_phase, m_wleft, m_tleft, m_cur, m_age, m_idx;
   logic [N-1:0] m_req, m_sticky;
   logic         m_fail, m_spur;

   function automatic exp_t model_out();
      exp_t e;
      e.req    = m_req;
      e.fail   = m_fail;
      e.idx    = 2'(m_idx);
      e.sticky = m_sticky;
      e.spur   = m_spur;
      e.busy   = (m_phase == 2);
      return e;
   endfunction

   function automatic void model_reset();
      m_phase  = 0;
      m_wleft  = 0;
      m_tleft  = 0;
      m_cur    = N - 1;
      m_age    = 0;
      m_idx    = 0;
      m_req    = '0;
      m_sticky = '0;
      m_fail   = 1'b0;
      m_spur   = 1'b0;
   endfunction

   function automatic void compare(input exp_t e, input string tag);
      exp_t g;
      g.req    = ping_req_o;
      g.fail   = ping_fail_o;
      g.idx    = fail_idx_o;
      g.sticky = fail_sticky_o;
      g.spur   = spurious_ok_o;
      g.busy   = busy_o;
      vectors++;
      if (g !== e) begin
         miscompares++;
         $display("FAIL %s t=%0t got req=%b fail=%b idx=%0d sticky=%b spur=%b busy=%b want req=%b fail=%b idx=%0d sticky=%b spur=%b busy=%b",
                  tag, $time, g.req, g.fail, g.idx, g.sticky, g.spur, g.busy,
                  e.req, e.fail, e.idx, e.sticky, e.spur, e.busy);
      end
   endfunction

   task automatic drive_and_model();
      logic [N-1:0] ok;
      int           c;
      ok = s_spur;
      if (m_phase == 2 && m_age == dly[m_cur]) ok[m_cur] = 1'b1;
      en_i          = s_en;
      alert_en_i    = s_aen;
      wait_cyc_i    = CW'(s_wait);
      timeout_cyc_i = CW'(s_tmo);
      ping_ok_i     = ok;
      fail_clr_i    = s_clr;
      m_fail   = 1'b0;
      m_spur   = |(ok & ~m_req);
      m_sticky = m_sticky & ~s_clr;
      if (!s_en) begin
         m_phase = 0;
         m_req   = '0;
      end else if (m_phase == 0) begin
         m_phase = 1;
         m_wleft = s_wait;
      end else if (m_phase == 1) begin
         if (m_wleft > 0) begin
            m_wleft--;
         end else if (s_aen != '0) begin
            c = m_cur;
            for (int k = 1; k <= N; k++) begin
               if (s_aen[(m_cur + k) % N]) begin
                  c = (m_cur + k) % N;
                  break;
               end
            end
            m_cur      = c;
            m_tleft    = (s_tmo < 1) ? 1 : s_tmo;
            m_phase    = 2;
            m_age      = 1;
            m_req      = '0;
            m_req[c]   = 1'b1;
         end
      end else begin
         if (ok[m_cur] || !s_aen[m_cur]) begin
            m_phase = 1;
            m_wleft = s_wait;
            m_req   = '0;
         end else if (m_tleft == 1) begin
            m_fail          = 1'b1;
            m_idx           = m_cur;
            m_sticky[m_cur] = 1'b1;
            m_phase         = 1;
            m_wleft         = s_wait;
            m_req           = '0;
         end else begin
            m_tleft--;
            m_age++;
         end
      end
      q.push_back(model_out());
      s_clr  = '0;
      s_spur = '0;
   endtask

   task automatic cycle(input int n);
      repeat (n) begin
         @(negedge clk_i);
         drive_and_model();
      end
   endtask

   // run until the coming cycle is ping cycle 'age' on channel 'ch'
   task automatic wait_for(input int ch, input int age);
      int i;
      for (i = 0; i < 200; i++) begin
         if (m_phase == 2 && m_cur == ch && m_age == age) break;
         cycle(1);
      end
      if (i == 200) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_for ch=%0d age=%0d not reached in 200 cycles", ch, age);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      model_reset();
      compare(model_out(), "async_reset");
      @(negedge clk_i);
      rst_i = 1'b0;
      drive_and_model();
   endtask

   // monitor: one expected entry per rising edge
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (q.size() > 0) compare(q.pop_front(), "cycle");
      end
   end

   initial begin
      model_reset();
      s_en   = 1'b1;
      s_aen  = 4'b1111;
      s_wait = 2;
      s_tmo  = 8;
      s_clr  = '0;
      s_spur = '0;
      foreach (dly[i]) dly[i] = 3;
      #2 rst_i = 1'b1;
      #1 compare(model_out(), "reset");
      @(negedge clk_i);
      rst_i = 1'b0;
      drive_and_model();
      cycle(40);

      dly[2] = 99;
      s_tmo  = 5;
      cycle(40);
      s_clr = 4'b0100;
      cycle(6);

      foreach (dly[i]) dly[i] = 4;
      s_tmo = 4;
      cycle(30);

      foreach (dly[i]) dly[i] = 2;
      s_aen = 4'b1010;
      cycle(30);
      s_aen = 4'b0000;
      cycle(15);
      s_aen = 4'b1111;

      foreach (dly[i]) dly[i] = 4;
      s_tmo = 8;
      wait_for(1, 2);
      s_en = 1'b0;
      cycle(3);
      s_en = 1'b1;
      cycle(20);
      wait_for(1, 2);
      s_aen = 4'b1101;
      cycle(5);
      s_aen = 4'b1111;
      cycle(10);

      wait_for(3, 1);
      s_spur = 4'b0001;
      cycle(10);

      foreach (dly[i]) dly[i] = 99;
      s_tmo = 0;
      cycle(20);

      foreach (dly[i]) dly[i] = 3;
      s_tmo = 8;
      wait_for(0, 2);
      do_reset();
      cycle(20);

      for (int seg = 0; seg < 25; seg++) begin
         s_en   = ($urandom_range(0, 9) != 0);
         s_aen  = 4'($urandom);
         s_wait = $urandom_range(0, 3);
         s_tmo  = $urandom_range(0, 6);
         foreach (dly[i]) dly[i] = $urandom_range(1, 8);
         if ($urandom_range(0, 2) == 0) s_clr = 4'($urandom);
         if ($urandom_range(0, 2) == 0) s_spur = 4'($urandom);
         cycle($urandom_range(10, 30));
      end

      @(posedge clk_i);
      #3;
      if (q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d expected entries left, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
